// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter with round-robin grant, LOCK hold and a per-strobe watchdog.
module wb_arbiter_2m #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [63:0] m0_adr_i,
  input  logic [63:0] m0_dat_i,
  input  logic [7:0]  m0_sel_i,
  output logic [63:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [63:0] m1_adr_i,
  input  logic [63:0] m1_dat_i,
  input  logic [7:0]  m1_sel_i,
  output logic [63:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [1:0]  gnt_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [63:0] s_adr_o,
  output logic [63:0] s_dat_o,
  output logic [7:0]  s_sel_o,
  input  logic [63:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TOUT} state_t;
  state_t           r_state;
  logic             r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic w_own0, w_own1, w_tout, w_cyc, w_lock, w_resp, w_wait;
  assign w_own0 = r_state == OWN0;
  assign w_own1 = r_state == OWN1;
  assign w_tout = r_state == TOUT;
  assign w_cyc  = w_own0 ? m0_cyc_i  : m1_cyc_i;
  assign w_lock = w_own0 ? m0_lock_i : m1_lock_i;
  assign w_resp = s_ack_i | s_err_i | s_rty_i;
  assign w_wait = s_stb_o & ~w_resp;
  assign s_cyc_o = w_own0 ? m0_cyc_i : w_own1 & m1_cyc_i;
  assign s_stb_o = w_own0 ? m0_stb_i : w_own1 & m1_stb_i;
  assign s_we_o  = w_own0 ? m0_we_i  : w_own1 & m1_we_i;
  assign s_adr_o = w_own0 ? m0_adr_i : w_own1 ? m1_adr_i : '0;
  assign s_dat_o = w_own0 ? m0_dat_i : w_own1 ? m1_dat_i : '0;
  assign s_sel_o = w_own0 ? m0_sel_i : w_own1 ? m1_sel_i : '0;
  assign gnt_o    = {w_own1 | (w_tout & r_owner), w_own0 | (w_tout & ~r_owner)};
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // responses reach only the owner, and only while its strobe is up
  assign m0_ack_o = w_own0 & m0_stb_i & s_ack_i;
  assign m0_rty_o = w_own0 & m0_stb_i & s_rty_i;
  assign m0_err_o = (w_own0 & m0_stb_i & s_err_i) | (w_tout & ~r_owner);
  assign m1_ack_o = w_own1 & m1_stb_i & s_ack_i;
  assign m1_rty_o = w_own1 & m1_stb_i & s_rty_i;
  assign m1_err_o = (w_own1 & m1_stb_i & s_err_i) | (w_tout & r_owner);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || r_last)) r_state <= OWN0;
          else if (m1_cyc_i) r_state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!w_cyc && !w_lock) begin
            r_state <= IDLE;
            r_last  <= w_own1;
            r_cnt   <= '0;
          end else if (w_wait && r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= TOUT;
            r_owner <= w_own1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_wait ? r_cnt + 1'b1 : '0;
          end
        end
        TOUT: begin
          r_state <= r_owner ? OWN1 : OWN0;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for wb_arbiter_2m.
module tb_wb_arbiter_2m;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic [63:0] m0_adr_i, m0_dat_i;
  logic [7:0]  m0_sel_i;
  logic [63:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic [63:0] m1_adr_i, m1_dat_i;
  logic [7:0]  m1_sel_i;
  logic [63:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [1:0]  gnt_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [63:0] s_adr_o, s_dat_o;
  logic [7:0]  s_sel_o;
  logic [63:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  wb_arbiter_2m #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .gnt_o(gnt_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i} = '0;
    {m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i} = '0;
    {m0_sel_i, m1_sel_i} = '0;
    {s_ack_i, s_err_i, s_rty_i} = '0;
    #1;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_acks", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 0);
    #12 rst = 1'b0;
    tick();
    // m0 single write
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
    m0_adr_i = 64'h1000; m0_dat_i = 64'hDEADBEEF_CAFEF00D; m0_sel_i = 8'hFF;
    m1_adr_i = 64'h5555; s_dat_i = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("wr_gnt_idle", gnt_o, 2'b00);
    chk("wr_scyc_idle", s_cyc_o, 0);
    tick();
    chk("wr_gnt", gnt_o, 2'b01);
    chk("wr_scyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    chk("wr_adr", s_adr_o, 64'h1000);
    chk("wr_dat", s_dat_o, 64'hDEADBEEF_CAFEF00D);
    chk("wr_sel", s_sel_o, 8'hFF);
    chk("rd_m0dat", m0_dat_o, 64'h0123_4567_89AB_CDEF);
    chk("rd_m1dat", m1_dat_o, 64'h0123_4567_89AB_CDEF);
    chk("wr_noack_early", m0_ack_o, 0);
    tick();
    s_ack_i = 1;
    #1;
    chk("wr_ack", m0_ack_o, 1);
    chk("wr_m1ack", m1_ack_o, 0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    chk("wr_ack_pulse", m0_ack_o, 0);
    tick();
    chk("wr_release", gnt_o, 2'b00);
    // both masters request continuously; m0 was last, so m1 goes first
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", gnt_o, k[0] ? 2'b01 : 2'b10);
      s_ack_i = 1;
      #1;
      chk("rr_ack_owner", k[0] ? m0_ack_o : m1_ack_o, 1);
      chk("rr_ack_other", k[0] ? m1_ack_o : m0_ack_o, 0);
      tick();
      s_ack_i = 0;
      if (k[0]) begin m0_cyc_i = 0; m0_stb_i = 0; end
      else begin m1_cyc_i = 0; m1_stb_i = 0; end
      tick();
      chk("rr_idle_gap", gnt_o, 2'b00);
      if (k < 7) begin
        if (k[0]) begin m0_cyc_i = 1; m0_stb_i = 1; end
        else begin m1_cyc_i = 1; m1_stb_i = 1; end
      end
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    chk("rr_stay_idle", gnt_o, 2'b00);
    // m1 locked read, gap, read, while m0 waits
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_lock_i = 1;
    tick();
    chk("lk_gnt", gnt_o, 2'b10);
    chk("lk_adr", s_adr_o, 64'h5555);
    chk("lk_we", s_we_o, 0);
    s_ack_i = 1;
    #1;
    chk("lk_ack1", m1_ack_o, 1);
    chk("lk_m0_noack", m0_ack_o, 0);
    tick();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("lk_scyc_gap", s_cyc_o, 0);
    tick();
    chk("lk_hold1", gnt_o, 2'b10);
    s_ack_i = 1;
    #1;
    chk("lk_stb_low_ignored", m1_ack_o, 0);
    s_ack_i = 0;
    tick();
    chk("lk_hold2", gnt_o, 2'b10);
    m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    #1;
    chk("lk_ack2", m1_ack_o, 1);
    tick();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_lock_i = 0;
    #1;
    chk("lk_still_m1", gnt_o, 2'b10);
    tick();
    chk("lk_release", gnt_o, 2'b00);
    tick();
    chk("lk_m0_gnt", gnt_o, 2'b01);
    // m0 strobes, slave silent: 16 strobe cycles then one TOUT cycle
    for (int i = 0; i < 16; i++) begin
      chk("to_stb", {s_cyc_o, s_stb_o, m0_err_o}, 3'b110);
      tick();
    end
    chk("to_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    chk("to_err", m0_err_o, 1);
    chk("to_m1", {m1_ack_o, m1_err_o, m1_rty_o}, 0);
    chk("to_gnt", gnt_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    chk("to_back_own", gnt_o, 2'b01);
    chk("to_err_once", m0_err_o, 0);
    tick();
    chk("to_release", gnt_o, 2'b00);
    // ack lands in the same cycle the counter reaches 15
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("lim_stb", s_stb_o, 1);
    s_ack_i = 1;
    #1;
    chk("lim_ack", m0_ack_o, 1);
    chk("lim_noerr", m0_err_o, 0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("lim_no_tout", {gnt_o, m0_err_o}, 3'b010);
    tick();
    chk("lim_release", gnt_o, 2'b00);
    // reset during m1 ownership
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 8'h0F;
    tick();
    chk("rs_gnt", gnt_o, 2'b10);
    m0_cyc_i = 1; m0_stb_i = 1;
    #2 rst = 1'b1;
    #1;
    chk("rs_gnt0", gnt_o, 2'b00);
    chk("rs_sctl", {s_cyc_o, s_stb_o, s_we_o}, 0);
    chk("rs_sbus", s_adr_o | s_dat_o | {56'd0, s_sel_o}, 0);
    #1 rst = 1'b0;
    tick();
    chk("rs_tie_m0", gnt_o, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
